poly_modq_writer: RTL and testbench
===================================

Name: poly_modq_writer

Overview:
- Front-end loader for the 13-bit coefficient RAM of the SNTRUP757 datapath.
- Accepts a stream of unsigned wide coefficients, such as raw multiply/accumulate results, over a valid/ready handshake.
- Reduces each coefficient exactly mod Q (4591) through a 3-stage pipelined Barrett reducer.
- Drives the RAM's synchronous write port, coefficient i going to address BASE_ADDR+i, and pulses done after the last write.

Parameters:
- Q, 4591, modulus.
- N_COEF, 761, coefficients per polynomial (p).
- IN_WIDTH, 26, input coefficient width (unsigned).
- RAM_WIDTH, 13, write data width.
- RAM_ADDR_BITS, 11, write address width.
- BASE_ADDR, 0, address of coefficient 0. BASE_ADDR+N_COEF <= 2**RAM_ADDR_BITS is checked at elaboration.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  begin loading one polynomial; honoured only in IDLE.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block can accept in_data.
- in_data  in  IN_WIDTH  unsigned coefficient.
- write_enable  out  1  RAM write strobe.
- write_address  out  RAM_ADDR_BITS  RAM write address.
- input_data  out  RAM_WIDTH  reduced coefficient to RAM.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse, the cycle after the last write.

Behaviour:
- Clock and reset (already decided): single clock clk; reset rst_n is synchronous and active-low.
- Reset values: all outputs 0, FSM in IDLE, input counter 0, all pipeline valid bits 0.
- Reset mid-operation aborts the load. No write_enable is issued after the reset edge, even for coefficients still in the pipeline. Partially written RAM contents are not cleaned up.

FSM states:
- IDLE: busy=0, in_ready=0. start=1 moves to RUN, clears the counter and sets busy=1 next cycle.
- RUN: in_ready=1. A transfer occurs when in_valid&&in_ready. When the transfer with index N_COEF-1 occurs, in_ready drops next cycle and the FSM moves to DRAIN.
- DRAIN: in_ready=0. Waits until all pipeline valid bits are 0, then moves to DONE.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE.
- start outside IDLE is ignored. start and in_valid in the same IDLE cycle: that in_data is not accepted.

Pipeline (fixed latency 3):
- A transfer in cycle n produces write_enable=1 in cycle n+3. write_address = BASE_ADDR + transfer index; input_data = in_data mod Q.
- Stage 1: register x; compute x*MU with MU = floor(2^39/Q), an elaboration constant.
- Stage 2: t = (x*MU)>>39; r = x - t*Q, with r in [0, 2Q).
- Stage 3: if r >= Q then r -= Q; register the write outputs.
- Each stage carries its own valid bit and index. There is no stall: the RAM always accepts, so bubbles from in_valid=0 propagate as write_enable=0.

Width and ordering rules:
- Results are exact for every in_data in [0, 2^IN_WIDTH).
- Addresses are strictly increasing and contiguous: BASE_ADDR .. BASE_ADDR+N_COEF-1. No wrap, guaranteed by the elaboration check.
- done rises in the cycle after the write of index N_COEF-1.

Optional Feature:
- Macro: MODQ_CENTERED_OUT_EN.
- Defined: stage 3 additionally maps a result r > (Q-1)/2 (2295) to r-Q. input_data is then the centred representative in [-2295, 2295] as 13-bit two's complement. Latency is unchanged.
- Undefined: input_data is in [0, Q-1].

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with start=1 and in_valid=1 -> all outputs 0, no write_enable. Release -> IDLE with busy=0.
- Full load: start, then feed in_data=i for i=0..760 with in_valid constantly 1 -> 761 writes, address i data i, each 3 cycles after its transfer. done pulses once, the cycle after the address-760 write. busy=0 that cycle.
- Reduction boundaries: 4590->4590, 4591->0, 4592->1, 21072690 (4591*4590)->0, 67108863->2216, 0->0.
- Gapped handshake: in_valid follows a pseudo-random 50% pattern -> addresses remain contiguous, no duplicate or skipped writes, latency exactly 3 per transfer. A second start during RUN is ignored.
- Reset mid-run after transfer 100 -> no write_enable from the reset edge on. A new start then writes index 0 at BASE_ADDR again.
- MODQ_CENTERED_OUT_EN defined: 2295->13'h08F7, 2296->13'h1709 (-2295), 4590->13'h1FFF (-1).

Source files
------------

// File: rtl/poly_modq_writer.sv
// Streams wide unsigned coefficients through a 3-stage Barrett reducer (mod Q) into the coefficient RAM write port.
// Optional macro MODQ_CENTERED_OUT_EN: write centred representatives in [-(Q-1)/2, (Q-1)/2] instead of [0, Q-1].
module poly_modq_writer #(
    parameter int Q             = 4591,
    parameter int N_COEF        = 761,
    parameter int IN_WIDTH      = 26,
    parameter int RAM_WIDTH     = 13,
    parameter int RAM_ADDR_BITS = 11,
    parameter int BASE_ADDR     = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [IN_WIDTH-1:0]      in_data,
    output logic                     write_enable,
    output logic [RAM_ADDR_BITS-1:0] write_address,
    output logic [RAM_WIDTH-1:0]     input_data,
    output logic                     busy,
    output logic                     done
);

    localparam int          SHIFT  = 39;
    localparam logic [63:0] MU64   = (64'd1 << SHIFT) / 64'(Q);
    localparam int          MU_W   = $clog2(MU64 + 64'd1);
    localparam int          PROD_W = IN_WIDTH + MU_W;
    localparam int          T_W    = PROD_W - SHIFT;
    localparam int          R_W    = $clog2(2 * Q);
    localparam int          CNT_W  = $clog2(N_COEF);

    localparam logic [MU_W-1:0]  MU   = MU_W'(MU64);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_COEF - 1);

    if (BASE_ADDR + N_COEF > 2 ** RAM_ADDR_BITS) begin : g_addr_range_check
        $error("poly_modq_writer: BASE_ADDR + N_COEF exceeds the RAM address space");
    end

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                   state;
    logic [CNT_W-1:0]         count;
    logic                     xfer;

    logic                     s1_valid;
    logic [IN_WIDTH-1:0]      s1_x;
    logic [RAM_ADDR_BITS-1:0] s1_addr;

    logic                     s2_valid;
    logic [IN_WIDTH-1:0]      s2_x;
    logic [T_W-1:0]           s2_t;
    logic [RAM_ADDR_BITS-1:0] s2_addr;

    logic [R_W-1:0]           r_raw;
    logic [R_W-1:0]           r_mod;
    logic [RAM_WIDTH-1:0]     r_out;

    assign xfer = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            count    <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state    <= RUN;
                        count    <= '0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    if (xfer) begin
                        count <= count + 1'b1;
                        if (count == LAST) begin
                            state    <= DRAIN;
                            in_ready <= 1'b0;
                        end
                    end
                end
                // The output register is the last stage, so done lands the cycle after the final write.
                DRAIN: begin
                    if (!s1_valid && !s2_valid) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Barrett quotient estimate is at most one short, so r lands in [0, 2Q) and fits R_W bits exactly.
    always_comb begin
        r_raw = R_W'(s2_x) - R_W'(s2_t) * R_W'(Q);
        r_mod = (r_raw >= R_W'(Q)) ? r_raw - R_W'(Q) : r_raw;
`ifdef MODQ_CENTERED_OUT_EN
        r_out = (r_mod > R_W'((Q - 1) / 2)) ? RAM_WIDTH'(r_mod) - RAM_WIDTH'(Q) : RAM_WIDTH'(r_mod);
`else
        r_out = RAM_WIDTH'(r_mod);
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid      <= 1'b0;
            s2_valid      <= 1'b0;
            write_enable  <= 1'b0;
            write_address <= '0;
            input_data    <= '0;
        end else begin
            s1_valid     <= xfer;
            s2_valid     <= s1_valid;
            write_enable <= s2_valid;
            if (xfer) begin
                s1_x    <= in_data;
                s1_addr <= RAM_ADDR_BITS'(BASE_ADDR) + RAM_ADDR_BITS'(count);
            end
            if (s1_valid) begin
                s2_x    <= s1_x;
                s2_t    <= T_W'((PROD_W'(s1_x) * PROD_W'(MU)) >> SHIFT);
                s2_addr <= s1_addr;
            end
            if (s2_valid) begin
                write_address <= s2_addr;
                input_data    <= r_out;
            end
        end
    end

endmodule

// File: tb/tb_poly_modq_writer.sv
// Self-checking bench for poly_modq_writer: random and directed loads checked against a queue-based reference model.
module tb_poly_modq_writer;

    localparam int Q             = 4591;
    localparam int N_COEF        = 761;
    localparam int IN_WIDTH      = 26;
    localparam int RAM_WIDTH     = 13;
    localparam int RAM_ADDR_BITS = 11;
    localparam int BASE_ADDR     = 0;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     start;
    logic                     in_valid;
    logic                     in_ready;
    logic [IN_WIDTH-1:0]      in_data;
    logic                     write_enable;
    logic [RAM_ADDR_BITS-1:0] write_address;
    logic [RAM_WIDTH-1:0]     input_data;
    logic                     busy;
    logic                     done;

    poly_modq_writer #(
        .Q(Q), .N_COEF(N_COEF), .IN_WIDTH(IN_WIDTH), .RAM_WIDTH(RAM_WIDTH),
        .RAM_ADDR_BITS(RAM_ADDR_BITS), .BASE_ADDR(BASE_ADDR)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .write_enable(write_enable), .write_address(write_address),
        .input_data(input_data), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                   due;
        int                   addr;
        logic [RAM_WIDTH-1:0] data;
    } wr_t;

    wr_t  exp_q[$];
    int   cyc;
    int   cnt;
    int   done_cycle;
    bit   m_idle;
    bit   m_run;
    int   checks;
    int   fails;

    logic [IN_WIDTH-1:0] bvals [8] = '{26'd4590, 26'd4591, 26'd4592, 26'd21072690,
                                       26'd67108863, 26'd0, 26'd2295, 26'd2296};

    function automatic logic [RAM_WIDTH-1:0] ref_mod(input longint x);
        longint r;
        r = x % Q;
`ifdef MODQ_CENTERED_OUT_EN
        if (r > (Q - 1) / 2) r = r - Q;
`endif
        return RAM_WIDTH'(r);
    endfunction

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            fails++;
            $display("[TB] FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, expv, cyc);
            $error("[TB] check %s", tag);
        end
    endtask

    // One clock: update the model from the inputs driven this cycle, then compare every output after the edge.
    task automatic apply_stimulus();
        bit rst_now;
        rst_now = !rst_n;
        if (!rst_now) begin
            if (m_run && in_valid) begin
                exp_q.push_back('{cyc + 3, BASE_ADDR + cnt, ref_mod(longint'(in_data))});
                if (cnt == N_COEF - 1) begin
                    m_run      = 1'b0;
                    done_cycle = cyc + 4;
                end
                cnt++;
            end else if (m_idle && start) begin
                m_idle     = 1'b0;
                m_run      = 1'b1;
                cnt        = 0;
                done_cycle = -1;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (rst_now) begin
            exp_q.delete();
            m_idle     = 1'b1;
            m_run      = 1'b0;
            done_cycle = -1;
        end
        if (done_cycle >= 0 && cyc == done_cycle + 1) m_idle = 1'b1;

        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            check_output("write_enable", 32'(write_enable), 32'd1);
            check_output("write_address", 32'(write_address), 32'(exp_q[0].addr));
            check_output("input_data", 32'(input_data), 32'(exp_q[0].data));
            void'(exp_q.pop_front());
        end else begin
            check_output("write_enable_idle", 32'(write_enable), 32'd0);
        end
        check_output("done", 32'(done), 32'(cyc == done_cycle));
        check_output("in_ready", 32'(in_ready), 32'(m_run));
        check_output("busy", 32'(busy), 32'(!m_idle && cyc != done_cycle));
    endtask

    // mode 0: data = index; mode 1: boundary values then random; mode 2: gapped valid plus stray starts.
    task automatic run_load(input int mode);
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = 26'd12345;
        apply_stimulus();
        start = 1'b0;
        for (int k = 0; k < 4000 && cnt < N_COEF; k++) begin
            case (mode)
                0: begin
                    in_valid = 1'b1;
                    in_data  = IN_WIDTH'(cnt);
                end
                1: begin
                    in_valid = 1'b1;
                    in_data  = (cnt < 8) ? bvals[cnt] : IN_WIDTH'($urandom());
                end
                default: begin
                    in_valid = 1'($urandom_range(0, 1));
                    in_data  = ($urandom_range(0, 7) == 0) ? bvals[$urandom_range(0, 7)] : IN_WIDTH'($urandom());
                    start    = ($urandom_range(0, 31) == 0);
                end
            endcase
            apply_stimulus();
        end
        start    = 1'b0;
        in_valid = 1'b0;
        check_output("load_complete", 32'(cnt), 32'(N_COEF));
        for (int k = 0; k < 20 && !(done_cycle >= 0 && cyc > done_cycle); k++) apply_stimulus();
        check_output("done_reached", 32'(done_cycle >= 0 && cyc > done_cycle), 32'd1);
        check_output("writes_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        checks     = 0;
        fails      = 0;
        cyc        = 0;
        cnt        = 0;
        done_cycle = -1;
        m_idle     = 1'b1;
        m_run      = 1'b0;
        rst_n      = 1'b0;
        start      = 1'b1;
        in_valid   = 1'b1;
        in_data    = 26'd777;

        $display("[TB] reset with start and in_valid held high");
        for (int i = 0; i < 3; i++) apply_stimulus();
        check_output("rst_write_address", 32'(write_address), 32'd0);
        check_output("rst_input_data", 32'(input_data), 32'd0);
        rst_n    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) apply_stimulus();

        $display("[TB] full load with data equal to index");
        run_load(0);
        $display("[TB] load with reduction boundary values");
        run_load(1);
        $display("[TB] gapped handshake with stray starts");
        run_load(2);

        $display("[TB] reset in the middle of a load");
        start = 1'b1;
        apply_stimulus();
        start = 1'b0;
        for (int k = 0; k < 400 && !(m_run && cnt == 101); k++) begin
            in_valid = 1'b1;
            in_data  = IN_WIDTH'($urandom());
            apply_stimulus();
        end
        check_output("midrun_point", 32'(cnt), 32'd101);
        rst_n    = 1'b0;
        in_valid = 1'b1;
        apply_stimulus();
        apply_stimulus();
        rst_n    = 1'b1;
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) apply_stimulus();
        run_load(1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
